// File: rtl/pipeline_stall_ctrl.sv
// Pipeline sequencing controller: hazard stall/flush merge, MULT/DIV occupancy
// tracker, debug halt/single-step FSM. Optional stall counter under STALL_CNT_EN.
module pipeline_stall_ctrl #(
  parameter int MD_LATENCY = 32,
  parameter int CNT_W      = 32
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_load_use,
  input  logic             i_branch_flush,
  input  logic             i_md_start,
  input  logic             i_md_use,
  input  logic             i_halt_req,
  input  logic             i_step_req,
  input  logic             i_resume,
  output logic             o_pc_en,
  output logic             o_if_id_en,
  output logic             o_if_id_flush,
  output logic             o_id_ex_flush,
  output logic             o_md_busy,
  output logic             o_md_done,
  output logic             o_halted,
  output logic [CNT_W-1:0] o_stall_cycles
);

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_HALT = 2'd1,
    ST_STEP = 2'd2
  } state_t;

  localparam logic [7:0] MD_LAT8 = 8'(MD_LATENCY);

  state_t     state_q, state_d;
  logic [7:0] md_cnt_q, md_cnt_d;

  logic md_stall;
  logic hz_stall;
  logic md_accept;
  logic is_halt;

  assign is_halt   = (state_q == ST_HALT);
  assign o_md_busy = (md_cnt_q != 8'd0);
  assign o_md_done = (md_cnt_q == 8'd1);
  assign md_stall  = o_md_busy & ~o_md_done & (i_md_use | i_md_start);
  assign hz_stall  = i_load_use | md_stall;

  // Outputs: HALT freezes fetch/decode; otherwise flush beats stall beats advance.
  always_comb begin
    o_pc_en       = 1'b1;
    o_if_id_en    = 1'b1;
    o_if_id_flush = 1'b0;
    o_id_ex_flush = 1'b0;
    o_halted      = 1'b0;
    md_accept     = 1'b0;
    if (is_halt) begin
      o_pc_en       = 1'b0;
      o_if_id_en    = 1'b0;
      o_id_ex_flush = 1'b1;
      o_halted      = 1'b1;
    end else if (i_branch_flush) begin
      o_if_id_flush = 1'b1;
      o_id_ex_flush = 1'b1;
    end else if (hz_stall) begin
      o_pc_en       = 1'b0;
      o_if_id_en    = 1'b0;
      o_id_ex_flush = 1'b1;
    end else begin
      md_accept     = i_md_start;
    end
  end

  always_comb begin
    md_cnt_d = md_cnt_q;
    if (md_accept) begin
      md_cnt_d = MD_LAT8;
    end else if (md_cnt_q != 8'd0) begin
      md_cnt_d = md_cnt_q - 8'd1;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN: begin
        if (i_halt_req) state_d = ST_HALT;
      end
      ST_HALT: begin
        if (i_resume)        state_d = ST_RUN;
        else if (i_step_req) state_d = ST_STEP;
      end
      ST_STEP: begin
        // One instruction retires into IF/ID on the first non-stalled cycle.
        if (o_pc_en) state_d = ST_HALT;
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= ST_RUN;
      md_cnt_q <= 8'd0;
    end else begin
      state_q  <= state_d;
      md_cnt_q <= md_cnt_d;
    end
  end

`ifdef STALL_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic             count_stall;

  assign count_stall = ~is_halt & hz_stall & ~i_branch_flush;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (count_stall && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign o_stall_cycles = stall_cnt_q;
`else
  assign o_stall_cycles = '0;
`endif

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Directed bench for pipeline_stall_ctrl (MD_LATENCY=4, CNT_W=4); counter
// expectations collapse to 0 when STALL_CNT_EN is not defined.
module tb_pipeline_stall_ctrl;

  localparam int MD_LAT = 4;
  localparam int CW     = 4;
`ifdef STALL_CNT_EN
  localparam bit CNT_ON = 1'b1;
`else
  localparam bit CNT_ON = 1'b0;
`endif

  logic          i_clk = 1'b0;
  logic          i_rst_n;
  logic          i_load_use, i_branch_flush, i_md_start, i_md_use;
  logic          i_halt_req, i_step_req, i_resume;
  logic          o_pc_en, o_if_id_en, o_if_id_flush, o_id_ex_flush;
  logic          o_md_busy, o_md_done, o_halted;
  logic [CW-1:0] o_stall_cycles;

  int n_checks = 0;
  int n_pass   = 0;

  pipeline_stall_ctrl #(.MD_LATENCY(MD_LAT), .CNT_W(CW)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_load_use(i_load_use), .i_branch_flush(i_branch_flush),
    .i_md_start(i_md_start), .i_md_use(i_md_use),
    .i_halt_req(i_halt_req), .i_step_req(i_step_req), .i_resume(i_resume),
    .o_pc_en(o_pc_en), .o_if_id_en(o_if_id_en),
    .o_if_id_flush(o_if_id_flush), .o_id_ex_flush(o_id_ex_flush),
    .o_md_busy(o_md_busy), .o_md_done(o_md_done), .o_halted(o_halted),
    .o_stall_cycles(o_stall_cycles)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Check the core control outputs as one packed word {pc_en,if_id_en,if_id_flush,id_ex_flush}.
  task automatic chk_ctl(input string tag, input logic [3:0] exp);
    chk(tag, {28'd0, o_pc_en, o_if_id_en, o_if_id_flush, o_id_ex_flush}, {28'd0, exp});
  endtask

  task automatic chk_md(input string tag, input logic busy, input logic done);
    chk(tag, {30'd0, o_md_busy, o_md_done}, {30'd0, busy, done});
  endtask

  task automatic chk_cnt(input string tag, input int v);
    chk(tag, 32'(o_stall_cycles), CNT_ON ? 32'(v) : 32'd0);
  endtask

  task automatic tick;
    @(posedge i_clk);
    #1;
  endtask

  task automatic clr;
    i_load_use = 0; i_branch_flush = 0; i_md_start = 0; i_md_use = 0;
    i_halt_req = 0; i_step_req = 0; i_resume = 0;
  endtask

  initial begin
    clr();
    i_rst_n = 1'b0;
    #12;
    chk_ctl("reset_ctl", 4'b1100);
    chk_md("reset_md", 0, 0);
    chk("reset_halted", {31'd0, o_halted}, 32'd0);
    chk("reset_cnt", 32'(o_stall_cycles), 32'd0);
    i_rst_n = 1'b1;
    tick();
    $display("reset released");

    // Load-use stall for one cycle
    i_load_use = 1; #1;
    chk_ctl("lu_stall", 4'b0001);
    tick(); clr(); #1;
    chk_ctl("lu_advance", 4'b1100);
    chk_cnt("lu_cnt", 1);
    $display("txn load_use: cnt=%0d", o_stall_cycles);

    // Branch flush overrides load-use
    i_load_use = 1; i_branch_flush = 1; #1;
    chk_ctl("flush_over_stall", 4'b1111);
    tick(); clr(); #1;
    chk_cnt("flush_cnt", 1);
    $display("txn flush_over_stall: cnt=%0d", o_stall_cycles);

    // MD start accepted at edge T, MFHI waiting from T+1
    i_md_start = 1; #1;
    chk_ctl("md_start_adv", 4'b1100);
    chk_md("md_pre", 0, 0);
    tick(); clr(); i_md_use = 1; #1;
    chk_md("md_t1", 1, 0);
    chk_ctl("md_t1_stall", 4'b0001);
    tick(); #1;
    chk_md("md_t2", 1, 0);
    chk_ctl("md_t2_stall", 4'b0001);
    tick(); #1;
    chk_md("md_t3", 1, 0);
    chk_ctl("md_t3_stall", 4'b0001);
    tick(); #1;
    chk_md("md_t4_done", 1, 1);
    chk_ctl("md_t4_release", 4'b1100);
    chk_cnt("md_cnt", 4);
    tick(); clr(); #1;
    chk_md("md_t5_idle", 0, 0);
    $display("txn md_latency: cnt=%0d", o_stall_cycles);

    // MD start squashed by flush
    i_md_start = 1; i_branch_flush = 1; #1;
    chk_ctl("md_squash_ctl", 4'b1111);
    tick(); clr(); #1;
    chk_md("md_squash", 0, 0);
    $display("txn md_squash");

    // Halt coincident with MD start: RUN outputs still apply this cycle
    i_md_start = 1; i_halt_req = 1; #1;
    chk_ctl("halt_entry_run", 4'b1100);
    tick(); clr(); i_load_use = 1; #1;
    chk("halted", {31'd0, o_halted}, 32'd1);
    chk_ctl("halt_ctl", 4'b0001);
    chk_md("halt_md_c1", 1, 0);
    tick(); tick(); tick(); #0;
    chk_md("halt_md_done", 1, 1);
    tick();
    chk_md("halt_md_idle", 0, 0);
    chk_cnt("halt_no_count", 4);
    clr();
    $display("txn halt: cnt=%0d", o_stall_cycles);

    // Single step with no stall
    i_step_req = 1; #1;
    chk_ctl("step_req_held", 4'b0001);
    tick(); clr(); #1;
    chk("step_not_halted", {31'd0, o_halted}, 32'd0);
    chk_ctl("step_advance", 4'b1100);
    tick(); #1;
    chk("step_back_halt", {31'd0, o_halted}, 32'd1);
    $display("txn step");

    // Single step that first stalls, ignoring halt_req
    i_step_req = 1;
    tick(); clr(); i_load_use = 1; i_halt_req = 1; #1;
    chk_ctl("step_stall", 4'b0001);
    tick(); clr(); #1;
    chk("step_held", {31'd0, o_halted}, 32'd0);
    chk_ctl("step_stall_release", 4'b1100);
    chk_cnt("step_cnt", 5);
    tick(); #1;
    chk("step2_back_halt", {31'd0, o_halted}, 32'd1);
    $display("txn step_stall: cnt=%0d", o_stall_cycles);

    // Resume wins over step
    i_step_req = 1; i_resume = 1;
    tick(); clr(); #1;
    chk("resume_run", {31'd0, o_halted}, 32'd0);
    chk_ctl("resume_ctl", 4'b1100);
    $display("txn resume");

    // Saturation: 20 load-use cycles
    i_load_use = 1;
    for (int k = 0; k < 20; k++) tick();
    clr(); #1;
    chk_cnt("saturate", 15);
    $display("txn saturate: cnt=%0d", o_stall_cycles);

    // Async reset mid-MD while halted
    i_md_start = 1; i_halt_req = 1;
    tick(); clr(); #1;
    chk_md("pre_rst_md", 1, 0);
    #2 i_rst_n = 1'b0;
    #1;
    chk_md("async_rst_md", 0, 0);
    chk("async_rst_halted", {31'd0, o_halted}, 32'd0);
    chk("async_rst_cnt", 32'(o_stall_cycles), 32'd0);
    chk_ctl("async_rst_ctl", 4'b1100);
    i_rst_n = 1'b1;
    tick(); #1;
    chk("post_rst_run", {31'd0, o_halted}, 32'd0);
    $display("txn async_reset");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pipeline_stall_ctrl.md
Name: pipeline_stall_ctrl

Overview:
Central pipeline sequencing controller for the 5-stage MIPS core. It merges the hazard unit's load-use stall and branch flush with a fixed-latency multiply/divide occupancy tracker and a debug halt/single-step machine. It produces the PC and IF/ID enables plus the IF/ID and ID/EX flush controls, and keeps a saturating stall-cycle counter.

Parameters:
MD_LATENCY, 32, cycles the MULT/DIV unit stays busy after an accepted start; legal range 2..255.
CNT_W, 32, width of the stall-cycle performance counter.

Ports:
i_clk  input  1  clock, rising edge
i_rst_n  input  1  asynchronous active-low reset
i_load_use  input  1  load-use stall request from hazard detection
i_branch_flush  input  1  branch misprediction flush from hazard detection
i_md_start  input  1  ID-stage instruction is MULT/MULTU/DIV/DIVU
i_md_use  input  1  ID-stage instruction reads HI/LO (MFHI/MFLO)
i_halt_req  input  1  debug halt request (level)
i_step_req  input  1  debug single-step request, sampled only in HALT
i_resume  input  1  debug resume, sampled only in HALT
o_pc_en  output  1  PC register write enable
o_if_id_en  output  1  IF/ID register write enable
o_if_id_flush  output  1  clear IF/ID to NOP
o_id_ex_flush  output  1  insert bubble into ID/EX
o_md_busy  output  1  MULT/DIV unit occupied
o_md_done  output  1  MULT/DIV result available this cycle
o_halted  output  1  core is in debug halt
o_stall_cycles  output  CNT_W  saturating count of hazard stall cycles

Behaviour:
- Reset (async, i_rst_n=0): state=RUN; md_cnt=0; stall counter=0. With all inputs at 0, outputs are pc_en=1, if_id_en=1, both flushes=0, md_busy=0, md_done=0, halted=0, stall_cycles=0.
- Registered state: FSM {RUN, HALT, STEP}; 8-bit md_cnt; stall counter. All other outputs are combinational from state, md_cnt and inputs.
- Define md_stall = md_busy & !md_done & (i_md_use | i_md_start).
- Define hz_stall = i_load_use | md_stall.
- Priority each cycle, in RUN or STEP:
  - branch_flush: pc_en=1, if_id_en=1, if_id_flush=1, id_ex_flush=1. Any stall is overridden because the ID instruction is wrong-path.
  - else hz_stall: pc_en=0, if_id_en=0, id_ex_flush=1, if_id_flush=0.
  - else: advance, with pc_en=1, if_id_en=1 and no flush.
- HALT outputs: pc_en=0, if_id_en=0, id_ex_flush=1, if_id_flush=0, halted=1. In-flight instructions drain and ID is held.
- MD tracker:
  - A start is accepted when i_md_start=1, the pipeline advances this cycle, there is no flush, and state is not HALT. md_cnt loads MD_LATENCY at that edge.
  - md_busy = (md_cnt != 0). md_done = (md_cnt == 1). md_cnt decrements every cycle while nonzero, including in HALT.
  - For a start accepted at edge T: busy during cycles T+1..T+MD_LATENCY; done during cycle T+MD_LATENCY only.
  - i_md_start while busy and not done stalls the core (structural hazard).
- FSM transitions:
  - RUN -> HALT when i_halt_req=1. The current cycle's outputs still follow RUN priority, so a coincident branch flush completes first.
  - HALT -> RUN on i_resume. HALT -> STEP on i_step_req. If both are asserted, resume wins.
  - STEP -> HALT after the first cycle in which pc_en=1. STEP ignores i_halt_req. While stalled, STEP holds.
- Stall counter: increments by 1 in every RUN/STEP cycle with hz_stall=1 and branch_flush=0. HALT cycles are not counted. Saturates at all-ones with no wrap.
- Reset mid-operation: md_cnt clears immediately, so busy and done drop. The FSM returns to RUN.

Optional Feature:
STALL_CNT_EN:
- Defined: the CNT_W stall counter is implemented as specified above.
- Undefined: no counter flops are synthesized and o_stall_cycles is tied to 0. All other behaviour is identical.

Test Plan:
- Load-use: i_load_use=1 for 1 cycle in RUN -> pc_en=0, if_id_en=0, id_ex_flush=1 that cycle; stall_cycles 0->1; pipeline advances the next cycle.
- Flush over stall: i_load_use=1 and i_branch_flush=1 together -> pc_en=1, if_id_flush=1, id_ex_flush=1; stall_cycles unchanged.
- MD latency, MD_LATENCY=4: start accepted at edge T -> md_busy high cycles T+1..T+4; md_done only at T+4. i_md_use held from T+1 -> stall in T+1..T+3 and release at T+4; stall_cycles=3.
- MD start squashed: i_md_start with i_branch_flush -> md_busy stays 0.
- Debug: i_halt_req pulse -> HALT with halted=1, pc_en=0. i_step_req -> exactly one cycle with pc_en=1, then back in HALT. i_step_req+i_resume together -> RUN with halted=0. md_cnt keeps counting while halted.
- Saturation/reset, with STALL_CNT_EN defined and CNT_W=4: 20 stall cycles -> o_stall_cycles=15. Deasserting i_rst_n mid-MD -> md_busy=0 and the counter returns to 0 asynchronously.
